// File: rtl/merge_sched_ctrl.sv
// Select/stall sequencer for the two-input run merger: picks the FIFO to dequeue,
// keeps exactly one terminator per merged run pair and counts finished pairs.
module merge_sched_ctrl #(
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned RUN_CNT_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_WIDTH-1:0]    i_a_key,
  input  logic                     i_a_empty,
  input  logic [DATA_WIDTH-1:0]    i_b_key,
  input  logic                     i_b_empty,
  input  logic                     i_fifo_out_full,
  output logic                     o_select_a,
  output logic                     o_stall,
  output logic                     o_drop,
  output logic                     o_term,
  output logic [2:0]               o_state,
  output logic [RUN_CNT_WIDTH-1:0] o_run_count
);

  typedef enum logic [2:0] {
    MERGE   = 3'd0,
    DRAIN_A = 3'd1,
    DRAIN_B = 3'd2,
    TERM_A  = 3'd3,
    TERM_B  = 3'd4
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [RUN_CNT_WIDTH-1:0] run_count_q;
  logic                     cnt_inc;
  logic                     illegal;
  logic                     az;
  logic                     bz;

  assign az = (i_a_key == '0);
  assign bz = (i_b_key == '0);

  // State register and pair counter; both hold while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= MERGE;
      run_count_q <= '0;
    end else begin
      if (!o_stall || illegal) state_q <= state_d;
      if (cnt_inc) run_count_q <= run_count_q + RUN_CNT_WIDTH'(1);
    end
  end

  // Next state and same-cycle dequeue controls; stalled cycles keep the safe defaults.
  always_comb begin
    state_d    = state_q;
    o_stall    = 1'b1;
    o_select_a = 1'b1;
    o_drop     = 1'b0;
    o_term     = 1'b0;
    cnt_inc    = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      DRAIN_B: begin
        o_stall = i_fifo_out_full | i_b_empty;
        if (!o_stall) begin
          o_select_a = 1'b0;
          if (bz) begin
            o_drop  = 1'b1;
            state_d = TERM_A;
          end
        end
      end
      DRAIN_A: begin
        o_stall = i_fifo_out_full | i_a_empty;
        if (!o_stall && az) begin
          o_drop  = 1'b1;
          state_d = TERM_B;
        end
      end
      TERM_A: begin
        o_stall = i_fifo_out_full | i_a_empty;
        if (!o_stall) begin
          o_term  = 1'b1;
          cnt_inc = 1'b1;
          state_d = MERGE;
        end
      end
      TERM_B: begin
        o_stall = i_fifo_out_full | i_b_empty;
        if (!o_stall) begin
          o_select_a = 1'b0;
          o_term     = 1'b1;
          cnt_inc    = 1'b1;
          state_d    = MERGE;
        end
      end
      default: begin
        // MERGE, and the unused codes which behave as MERGE.
        o_stall = i_fifo_out_full | i_a_empty | i_b_empty;
        if (!o_stall) begin
          case ({az, bz})
            2'b00: o_select_a = (i_a_key <= i_b_key);
            2'b10: begin
              o_select_a = 1'b0;
              state_d    = DRAIN_B;
            end
            2'b01: state_d = DRAIN_A;
            default: begin
              o_drop  = 1'b1;
              state_d = TERM_B;
            end
          endcase
        end
        if (state_q != MERGE) begin
          illegal = 1'b1;
          state_d = MERGE;
        end
      end
    endcase

    if (i_rst) begin
      o_stall    = 1'b1;
      o_select_a = 1'b1;
      o_drop     = 1'b0;
      o_term     = 1'b0;
      cnt_inc    = 1'b0;
    end
  end

  assign o_state     = state_q;
  assign o_run_count = run_count_q;

endmodule

// File: tb/tb_merge_sched_ctrl.sv
// Bench for merge_sched_ctrl: FIFO contents are queues, the expected dequeue stream
// of each run pair is derived from a stable merge plus the terminator rule.
module tb_merge_sched_ctrl;

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 2;
  localparam int          CNT_MOD = 1 << CW;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_a_key;
  logic          i_a_empty;
  logic [DW-1:0] i_b_key;
  logic          i_b_empty;
  logic          i_fifo_out_full;
  logic          o_select_a;
  logic          o_stall;
  logic          o_drop;
  logic          o_term;
  logic [2:0]    o_state;
  logic [CW-1:0] o_run_count;

  merge_sched_ctrl #(.DATA_WIDTH(DW), .RUN_CNT_WIDTH(CW)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_a_key        (i_a_key),
    .i_a_empty      (i_a_empty),
    .i_b_key        (i_b_key),
    .i_b_empty      (i_b_empty),
    .i_fifo_out_full(i_fifo_out_full),
    .o_select_a     (o_select_a),
    .o_stall        (o_stall),
    .o_drop         (o_drop),
    .o_term         (o_term),
    .o_state        (o_state),
    .o_run_count    (o_run_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit src_a;
    bit drop;
    bit term;
  } pop_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  pop_t          exp_q[$];
  bit            merge_open = 1'b1;
  bit            full = 1'b0;
  bit            force_ae = 1'b0;
  bit            force_be = 1'b0;
  int            exp_cnt = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Nonzero keys merge stably (ties to A); the terminator of the run that supplied
  // the last data tuple is dropped (A when there is no data) and the other is forwarded.
  function automatic void build_expected();
    int na = qa.size() - 1;
    int nb = qb.size() - 1;
    int i = 0;
    int j = 0;
    bit last_b = 1'b0;
    exp_q.delete();
    while (i < na || j < nb) begin
      if (j >= nb || (i < na && qa[i] <= qb[j])) begin
        exp_q.push_back('{1'b1, 1'b0, 1'b0});
        i++;
        last_b = 1'b0;
      end else begin
        exp_q.push_back('{1'b0, 1'b0, 1'b0});
        j++;
        last_b = 1'b1;
      end
    end
    if (last_b) begin
      exp_q.push_back('{1'b0, 1'b1, 1'b0});
      exp_q.push_back('{1'b1, 1'b0, 1'b1});
    end else begin
      exp_q.push_back('{1'b1, 1'b1, 1'b0});
      exp_q.push_back('{1'b0, 1'b0, 1'b1});
    end
    merge_open = 1'b1;
  endfunction

  // One clock: drive after the edge, check controls at negedge, check state after the edge.
  task automatic cycle(input bit rst);
    bit         ae, be, need_a, need_b, st_e, sel_e, drop_e, term_e;
    logic [2:0] st_before;
    pop_t       e;
    ae = (qa.size() == 0) || force_ae;
    be = (qb.size() == 0) || force_be;
    i_rst           = rst;
    i_fifo_out_full = full;
    i_a_empty       = ae;
    i_b_empty       = be;
    i_a_key         = (qa.size() != 0) ? qa[0] : rnd_key();
    i_b_key         = (qb.size() != 0) ? qb[0] : rnd_key();
    need_a = 1'b1;
    need_b = 1'b1;
    if (!merge_open && exp_q.size() != 0) begin
      need_a = exp_q[0].src_a;
      need_b = !exp_q[0].src_a;
    end
    st_e   = rst || full || (need_a && ae) || (need_b && be);
    sel_e  = 1'b1;
    drop_e = 1'b0;
    term_e = 1'b0;
    if (!st_e && exp_q.size() != 0) begin
      sel_e  = exp_q[0].src_a;
      drop_e = exp_q[0].drop;
      term_e = exp_q[0].term;
    end
    @(negedge i_clk);
    chk("stall", DW'(o_stall), DW'(st_e));
    chk("select_a", DW'(o_select_a), DW'(sel_e));
    chk("drop", DW'(o_drop), DW'(drop_e));
    chk("term", DW'(o_term), DW'(term_e));
    st_before = o_state;
    @(posedge i_clk);
    #1;
    if (rst) begin
      exp_cnt = 0;
      chk("reset_state", DW'(o_state), DW'(0));
    end else if (st_e) begin
      chk("stall_hold_state", DW'(o_state), DW'(st_before));
    end else if (exp_q.size() != 0) begin
      if (merge_open && (qa[0] == '0 || qb[0] == '0)) merge_open = 1'b0;
      e = exp_q.pop_front();
      if (e.src_a) void'(qa.pop_front());
      else void'(qb.pop_front());
      if (e.term) begin
        exp_cnt = (exp_cnt + 1) % CNT_MOD;
        chk("pair_end_state", DW'(o_state), DW'(0));
      end
    end
    chk("run_count", DW'(o_run_count), DW'(exp_cnt));
  endtask

  task automatic finish_pair(input int pf, input int pe, input bit window);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      full     = window ? (n >= 2 && n < 5) : (int'($urandom_range(99)) < pf);
      force_ae = int'($urandom_range(99)) < pe;
      force_be = int'($urandom_range(99)) < pe;
      cycle(1'b0);
      n++;
    end
    full     = 1'b0;
    force_ae = 1'b0;
    force_be = 1'b0;
    chk("pair_done", DW'(exp_q.size()), DW'(0));
  endtask

  task automatic rand_run(output logic [DW-1:0] r[$]);
    int len = $urandom_range(5);
    logic [DW-1:0] k;
    r.delete();
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(4) == 0) k = {1'b1, DW'(rnd_key()) >> 1};
      else k = DW'($urandom_range(6, 1));
      r.push_back(k);
    end
    r.sort();
    r.push_back('0);
  endtask

  initial begin
    logic [DW-1:0] ra[$];
    logic [DW-1:0] rb[$];
    i_rst = 1'b1;
    i_fifo_out_full = 1'b0;
    i_a_empty = 1'b1;
    i_b_empty = 1'b1;
    i_a_key = '0;
    i_b_key = '0;
    @(posedge i_clk);
    #1;
    cycle(1'b1);
    cycle(1'b1);

    // Interleaved runs, no backpressure.
    qa = '{1, 4, 6, 0};
    qb = '{2, 3, 7, 0};
    build_expected();
    finish_pair(0, 0, 1'b0);

    // Equal keys.
    qa = '{5, 0};
    qb = '{5, 0};
    build_expected();
    finish_pair(0, 0, 1'b0);

    // Backpressure window in the middle of the interleaved pair.
    qa = '{1, 4, 6, 0};
    qb = '{2, 3, 7, 0};
    build_expected();
    finish_pair(0, 0, 1'b1);

    // Terminator-only run on A while B is empty for four cycles.
    qa = '{0};
    qb = '{9, 0};
    build_expected();
    force_be = 1'b1;
    repeat (4) cycle(1'b0);
    force_be = 1'b0;
    cycle(1'b0);
    chk("drain_b_entry", DW'(o_state), DW'(2));
    finish_pair(0, 0, 1'b0);

    // Random runs with random backpressure and empty flags.
    for (int p = 0; p < 24; p++) begin
      rand_run(ra);
      rand_run(rb);
      qa = ra;
      qb = rb;
      build_expected();
      finish_pair((p < 8) ? 0 : 25, (p < 8) ? 0 : 25, 1'b0);
    end

    // Reset while in DRAIN_B with two completed pairs.
    cycle(1'b1);
    qa = '{0};
    qb = '{0};
    build_expected();
    finish_pair(0, 0, 1'b0);
    qa = '{5, 0};
    qb = '{5, 0};
    build_expected();
    finish_pair(0, 0, 1'b0);
    qa = '{0};
    qb = '{8, 9, 0};
    build_expected();
    cycle(1'b0);
    chk("pre_reset_state", DW'(o_state), DW'(2));
    chk("pre_reset_count", DW'(o_run_count), DW'(2));
    cycle(1'b1);
    chk("post_reset_count", DW'(o_run_count), DW'(0));
    qa.delete();
    qb.delete();
    exp_q.delete();
    merge_open = 1'b1;

    // Counter wrap over five empty pairs: 1,2,3,0,1.
    for (int p = 0; p < 5; p++) begin
      qa = '{0};
      qb = '{0};
      build_expected();
      finish_pair(0, 0, 1'b0);
      chk("wrap_count", DW'(o_run_count), DW'((p + 1) % CNT_MOD));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
